// File: rtl/baud_pkg.sv
// Shared constants, config-source select type and width helper for the
// fractional baud-rate generator.
package baud_pkg;

  localparam int unsigned DIV_MIN     = 2;
  localparam int unsigned DEF_DIV_W   = 8;
  localparam int unsigned DEF_FRAC_W  = 4;
  localparam int unsigned DEF_OVS     = 16;
  localparam int unsigned DEF_DIVISOR = 163;

  // Source of the active divisor/fraction on the next edge.
  typedef enum logic [1:0] {
    CFG_HOLD   = 2'd0,
    CFG_SHADOW = 2'd1,
    CFG_DIRECT = 2'd2
  } cfg_sel_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N counter with a runtime limit: counts 0..limit-1 on each advance,
// pulses wrap on the advance that returns it to 0.
module mod_n_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         adv,
  input  logic [W:0]   limit,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W:0] last;

  // limit is one bit wider so a full 2**W period still has a reachable last value
  assign last = limit - (W+1)'(1);
  assign wrap = adv && ({1'b0, count} == last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (adv) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/baud_rate_gen_frac.sv
// Programmable baud-rate generator with fractional divisor, shadowed config
// applied at period boundaries, oversample tick and derived bit tick.
module baud_rate_gen_frac
  import baud_pkg::*;
#(
  parameter int unsigned DIV_W   = DEF_DIV_W,
  parameter int unsigned FRAC_W  = DEF_FRAC_W,
  parameter int unsigned OVS     = DEF_OVS,
  parameter int unsigned DEF_DIV = DEF_DIVISOR
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  cfg_load,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [FRAC_W-1:0]     cfg_frac,
  output logic                  cfg_pending,
  output logic                  cfg_err,
  output logic                  tick,
  output logic                  bit_tick,
  output logic [DIV_W-1:0]      q,
  output logic [clog2(OVS)-1:0] ovs_q
);

  localparam int unsigned    OVS_W   = clog2(OVS);
  localparam logic [OVS_W:0] OVS_LIM = (OVS_W+1)'(OVS);

  logic [DIV_W-1:0]  div_act;
  logic [FRAC_W-1:0] frac_act;
  logic [DIV_W-1:0]  div_shd;
  logic [FRAC_W-1:0] frac_shd;
  logic [FRAC_W-1:0] acc;
  logic [DIV_W:0]    lim;
  logic [FRAC_W:0]   acc_sum;
  logic [DIV_W-1:0]  div_new;
  logic              load_bad;
  logic              upd;
  cfg_sel_e          sel;
  logic [DIV_W-1:0]  sel_div;
  logic [FRAC_W-1:0] sel_frac;

  assign load_bad = cfg_div < DIV_W'(DIV_MIN);
  assign div_new  = load_bad ? DIV_W'(DIV_MIN) : cfg_div;
  assign upd      = tick || !en;
  assign acc_sum  = {1'b0, acc} + {1'b0, frac_act};

  // A load landing on an update point bypasses the shadow registers.
  always_comb begin
    sel = CFG_HOLD;
    if (upd && cfg_load) begin
      sel = CFG_DIRECT;
    end else if (upd && cfg_pending) begin
      sel = CFG_SHADOW;
    end
  end

  always_comb begin
    sel_div  = div_shd;
    sel_frac = frac_shd;
    if (sel == CFG_DIRECT) begin
      sel_div  = div_new;
      sel_frac = cfg_frac;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_shd     <= DIV_W'(DEF_DIV);
      frac_shd    <= '0;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      if (cfg_load) begin
        cfg_err <= load_bad;
      end
      if (sel != CFG_HOLD) begin
        cfg_pending <= 1'b0;
      end else if (cfg_load) begin
        div_shd     <= div_new;
        frac_shd    <= cfg_frac;
        cfg_pending <= 1'b1;
      end
    end
  end

  // lim is DIV_W+1 bits so a carry on the largest divisor yields 2**DIV_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_act  <= DIV_W'(DEF_DIV);
      frac_act <= '0;
      acc      <= '0;
      lim      <= (DIV_W+1)'(DEF_DIV);
    end else if (sel != CFG_HOLD) begin
      div_act  <= sel_div;
      frac_act <= sel_frac;
      acc      <= '0;
      lim      <= {1'b0, sel_div};
    end else if (!en) begin
      acc <= '0;
      lim <= {1'b0, div_act};
    end else if (tick) begin
      acc <= acc_sum[FRAC_W-1:0];
      lim <= {1'b0, div_act} + (DIV_W+1)'(acc_sum[FRAC_W]);
    end
  end

  mod_n_counter #(.W(DIV_W)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!en),
    .adv     (en),
    .limit   (lim),
    .count   (q),
    .wrap    (tick)
  );

  mod_n_counter #(.W(OVS_W)) u_ovs (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!en),
    .adv     (tick),
    .limit   (OVS_LIM),
    .count   (ovs_q),
    .wrap    (bit_tick)
  );

endmodule

// File: tb/tb_baud_rate_gen_frac.sv
// Self-checking bench for baud_rate_gen_frac: closed-form period model
// (period n ends at n*div + floor((n-1)*frac/2**FRAC_W)) plus targeted scenarios.
module tb_baud_rate_gen_frac;

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned FRAC_W  = 4;
  localparam int unsigned OVS     = 16;
  localparam int unsigned DEF_DIV = 10;
  localparam int unsigned OVS_W   = 4;

  logic              clk;
  logic              reset_n;
  logic              en;
  logic              cfg_load;
  logic [DIV_W-1:0]  cfg_div;
  logic [FRAC_W-1:0] cfg_frac;
  logic              cfg_pending;
  logic              cfg_err;
  logic              tick;
  logic              bit_tick;
  logic [DIV_W-1:0]  q;
  logic [OVS_W-1:0]  ovs_q;

  baud_rate_gen_frac #(
    .DIV_W   (DIV_W),
    .FRAC_W  (FRAC_W),
    .OVS     (OVS),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .cfg_load    (cfg_load),
    .cfg_div     (cfg_div),
    .cfg_frac    (cfg_frac),
    .cfg_pending (cfg_pending),
    .cfg_err     (cfg_err),
    .tick        (tick),
    .bit_tick    (bit_tick),
    .q           (q),
    .ovs_q       (ovs_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks;
  int unsigned failures;

  // reference model state
  int unsigned m_div, m_frac, m_sdiv, m_sfrac;
  int unsigned m_t;      // enabled cycles completed in the current epoch
  int unsigned m_ticks;  // ticks since enable
  bit          m_pend, m_err;

  // last observed / expected cycle
  logic [15:0]      obs_v, exp_v;
  logic             obs_tick, obs_pend, obs_err;
  logic [DIV_W-1:0] obs_q, max_q;
  logic [OVS_W-1:0] obs_ovs;
  int unsigned      exp_q;
  int unsigned      cyc_n;
  int unsigned      trace_bad, bad_cyc;
  logic [15:0]      bad_obs, bad_exp;
  bit               pend_seen;

  function automatic int unsigned period_end(input int unsigned n, input int unsigned div,
                                             input int unsigned frac);
    if (n == 0) return 0;
    return n * div + (((n - 1) * frac) >> FRAC_W);
  endfunction

  task automatic model_reset();
    m_div = DEF_DIV; m_frac = 0; m_sdiv = DEF_DIV; m_sfrac = 0;
    m_t = 0; m_ticks = 0; m_pend = 1'b0; m_err = 1'b0;
  endtask

  // One clock cycle: drive, sample, compare against model, advance model.
  task automatic cyc(input bit e, input bit ld, input int unsigned d, input int unsigned f);
    int unsigned n, e_ovs, ndiv;
    bit          e_tick, e_bit, upd;
    @(negedge clk);
    en = e; cfg_load = ld; cfg_div = DIV_W'(d); cfg_frac = FRAC_W'(f);
    #1;
    cyc_n++;
    obs_tick = tick; obs_q = q; obs_ovs = ovs_q; obs_pend = cfg_pending; obs_err = cfg_err;
    obs_v = {tick, bit_tick, q, ovs_q, cfg_pending, cfg_err};
    if (q > max_q) max_q = q;
    pend_seen = pend_seen | cfg_pending;
    n = 0;
    while (period_end(n + 1, m_div, m_frac) <= m_t) n++;
    exp_q  = m_t - period_end(n, m_div, m_frac);
    e_tick = e && (period_end(n + 1, m_div, m_frac) == m_t + 1);
    e_ovs  = m_ticks % OVS;
    e_bit  = e_tick && (e_ovs == OVS - 1);
    exp_v  = {e_tick, e_bit, DIV_W'(exp_q), OVS_W'(e_ovs), m_pend, m_err};
    if (obs_v !== exp_v) begin
      if (trace_bad == 0) begin bad_cyc = cyc_n; bad_obs = obs_v; bad_exp = exp_v; end
      trace_bad++;
    end
    upd  = e_tick || !e;
    ndiv = (d < 2) ? 2 : d;
    if (ld) m_err = (d < 2);
    if (upd && (ld || m_pend)) begin
      if (ld) begin m_div = ndiv; m_frac = f; end
      else begin m_div = m_sdiv; m_frac = m_sfrac; end
      m_pend = 1'b0;
      m_t = 0;
    end else begin
      if (ld) begin m_sdiv = ndiv; m_sfrac = f; m_pend = 1'b1; end
      m_t = e ? m_t + 1 : 0;
    end
    m_ticks = e ? m_ticks + (e_tick ? 1 : 0) : 0;
  endtask

  task automatic next_tick(output int unsigned gap);
    gap = 0;
    for (int unsigned i = 1; i <= 1000; i++) begin
      cyc(1'b1, 1'b0, 0, 0);
      if (obs_tick === 1'b1) begin gap = i; return; end
    end
    checks++; failures++;
    $display("FAIL tick_timeout: no tick within 1000 cycles (got none, required one)");
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b1; cfg_load = 1'b1; cfg_div = 8'd3; cfg_frac = 4'd5;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({tick, bit_tick, q, ovs_q, cfg_pending, cfg_err} !== 16'h0) begin
      failures++;
      $display("FAIL reset_state: got=%h expected=0000", {tick, bit_tick, q, ovs_q, cfg_pending, cfg_err});
    end
    en = 1'b0; cfg_load = 1'b0;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_defaults();
    int unsigned first_tick, first_bit, n_tick, n_bit;
    first_tick = 0; first_bit = 0; n_tick = 0; n_bit = 0; max_q = '0; trace_bad = 0;
    for (int unsigned i = 1; i <= 330; i++) begin
      cyc(1'b1, 1'b0, 0, 0);
      if (obs_tick === 1'b1) begin n_tick++; if (first_tick == 0) first_tick = i; end
      if (obs_v[14] === 1'b1) begin n_bit++; if (first_bit == 0) first_bit = i; end
    end
    checks++; if (first_tick != 10) begin failures++; $display("FAIL defaults_first_tick: got %0d required 10", first_tick); end
    checks++; if (n_tick != 33) begin failures++; $display("FAIL defaults_tick_count: got %0d required 33", n_tick); end
    checks++; if (first_bit != 160) begin failures++; $display("FAIL defaults_first_bit_tick: got %0d required 160", first_bit); end
    checks++; if (n_bit != 2) begin failures++; $display("FAIL defaults_bit_tick_count: got %0d required 2", n_bit); end
    checks++; if (max_q !== 8'd9) begin failures++; $display("FAIL defaults_max_q: got %0d required 9", max_q); end
    checks++;
    if (trace_bad != 0) begin
      failures++;
      $display("FAIL defaults_trace: %0d cycles differ, first at cycle %0d got=%h required=%h", trace_bad, bad_cyc, bad_obs, bad_exp);
    end
  endtask

  task automatic test_async_reset();
    int unsigned gap;
    bit found;
    trace_bad = 0; found = 1'b0;
    for (int unsigned i = 0; i < 400 && !found; i++) begin
      cyc(1'b1, 1'b0, 0, 0);
      if (exp_q == 2 && m_ticks % OVS == 5) found = 1'b1;
    end
    if (!found) begin checks++; failures++; $display("FAIL async_setup: q=2/ovs_q=5 not reached (got none, required one)"); end
    cyc(1'b1, 1'b1, 1, 0);
    repeat (4) cyc(1'b1, 1'b0, 0, 0);
    checks++;
    if (obs_q !== 8'd7 || obs_ovs !== 4'd5 || obs_pend !== 1'b1 || obs_err !== 1'b1) begin
      failures++;
      $display("FAIL async_pre_state: got q=%0d ovs_q=%0d pend=%b err=%b required 7 5 1 1", obs_q, obs_ovs, obs_pend, obs_err);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({tick, bit_tick, q, ovs_q, cfg_pending, cfg_err} !== 16'h0) begin
      failures++;
      $display("FAIL async_reset_outputs: got=%h required=0000", {tick, bit_tick, q, ovs_q, cfg_pending, cfg_err});
    end
    en = 1'b0; cfg_load = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    next_tick(gap);
    checks++; if (gap != 10) begin failures++; $display("FAIL async_first_period: got %0d required 10", gap); end
    next_tick(gap);
    checks++; if (gap != 10) begin failures++; $display("FAIL async_second_period: got %0d required 10", gap); end
    checks++;
    if (trace_bad != 0) begin
      failures++;
      $display("FAIL async_trace: %0d cycles differ, first at cycle %0d got=%h required=%h", trace_bad, bad_cyc, bad_obs, bad_exp);
    end
  endtask

  task automatic test_fraction();
    int unsigned gap;
    int unsigned want [6] = '{4, 4, 5, 4, 5, 4};
    trace_bad = 0;
    cyc(1'b0, 1'b1, 4, 8);
    cyc(1'b0, 1'b0, 0, 0);
    for (int unsigned i = 0; i < 6; i++) begin
      next_tick(gap);
      checks++;
      if (gap != want[i]) begin failures++; $display("FAIL fraction_period%0d: got %0d required %0d", i, gap, want[i]); end
    end
    checks++;
    if (trace_bad != 0) begin
      failures++;
      $display("FAIL fraction_trace: %0d cycles differ, first at cycle %0d got=%h required=%h", trace_bad, bad_cyc, bad_obs, bad_exp);
    end
  endtask

  task automatic test_mid_load();
    int unsigned gap;
    trace_bad = 0;
    cyc(1'b0, 1'b1, 10, 0);
    for (int unsigned i = 0; i < 50; i++) begin
      cyc(1'b1, 1'b0, 0, 0);
      if (exp_q == 2) break;
    end
    cyc(1'b1, 1'b1, 6, 0);
    cyc(1'b1, 1'b0, 0, 0);
    checks++; if (obs_pend !== 1'b1) begin failures++; $display("FAIL midload_pending: got %b required 1", obs_pend); end
    next_tick(gap);
    checks++; if (gap != 5 || obs_q !== 8'd9) begin failures++; $display("FAIL midload_old_tick: got gap=%0d q=%0d required 5 9", gap, obs_q); end
    next_tick(gap);
    checks++; if (gap != 6) begin failures++; $display("FAIL midload_new_period: got %0d required 6", gap); end
    checks++;
    if (trace_bad != 0) begin
      failures++;
      $display("FAIL midload_trace: %0d cycles differ, first at cycle %0d got=%h required=%h", trace_bad, bad_cyc, bad_obs, bad_exp);
    end
  endtask

  task automatic test_load_at_tick();
    int unsigned gap1, gap2;
    trace_bad = 0;
    for (int unsigned i = 0; i < 50; i++) begin
      cyc(1'b1, 1'b0, 0, 0);
      if (exp_q == 4) break;
    end
    pend_seen = 1'b0;
    cyc(1'b1, 1'b1, 3, 0);
    checks++; if (obs_tick !== 1'b1) begin failures++; $display("FAIL attick_tick: got %b required 1", obs_tick); end
    next_tick(gap1);
    next_tick(gap2);
    checks++; if (gap1 != 3 || gap2 != 3) begin failures++; $display("FAIL attick_periods: got %0d,%0d required 3,3", gap1, gap2); end
    checks++; if (pend_seen) begin failures++; $display("FAIL attick_pending: got 1 required 0"); end
    checks++;
    if (trace_bad != 0) begin
      failures++;
      $display("FAIL attick_trace: %0d cycles differ, first at cycle %0d got=%h required=%h", trace_bad, bad_cyc, bad_obs, bad_exp);
    end
  endtask

  task automatic test_illegal();
    int unsigned gap1, gap2;
    trace_bad = 0;
    for (int unsigned i = 0; i < 50; i++) begin
      cyc(1'b1, 1'b0, 0, 0);
      if (exp_q == 0) break;
    end
    cyc(1'b1, 1'b1, 1, 0);
    cyc(1'b1, 1'b0, 0, 0);
    checks++;
    if (obs_err !== 1'b1 || obs_pend !== 1'b1 || obs_tick !== 1'b1) begin
      failures++;
      $display("FAIL illegal_flags: got err=%b pend=%b tick=%b required 1 1 1", obs_err, obs_pend, obs_tick);
    end
    next_tick(gap1);
    next_tick(gap2);
    checks++; if (gap1 != 2 || gap2 != 2) begin failures++; $display("FAIL illegal_periods: got %0d,%0d required 2,2", gap1, gap2); end
    cyc(1'b1, 1'b1, 5, 0);
    cyc(1'b1, 1'b0, 0, 0);
    checks++; if (obs_err !== 1'b0) begin failures++; $display("FAIL illegal_err_clear: got %b required 0", obs_err); end
    next_tick(gap1);
    next_tick(gap2);
    checks++; if (gap2 != 5) begin failures++; $display("FAIL illegal_recover_period: got %0d required 5", gap2); end
    checks++;
    if (trace_bad != 0) begin
      failures++;
      $display("FAIL illegal_trace: %0d cycles differ, first at cycle %0d got=%h required=%h", trace_bad, bad_cyc, bad_obs, bad_exp);
    end
  endtask

  task automatic test_boundary();
    int unsigned gap;
    int unsigned want [5] = '{255, 255, 256, 255, 256};
    trace_bad = 0;
    cyc(1'b0, 1'b1, 255, 8);
    max_q = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      next_tick(gap);
      checks++;
      if (gap != want[i]) begin failures++; $display("FAIL boundary_period%0d: got %0d required %0d", i, gap, want[i]); end
    end
    checks++; if (max_q !== 8'd255) begin failures++; $display("FAIL boundary_max_q: got %0d required 255", max_q); end
    checks++;
    if (trace_bad != 0) begin
      failures++;
      $display("FAIL boundary_trace: %0d cycles differ, first at cycle %0d got=%h required=%h", trace_bad, bad_cyc, bad_obs, bad_exp);
    end
  endtask

  task automatic test_random();
    bit          e, ld;
    int unsigned d, f;
    trace_bad = 0;
    for (int unsigned i = 0; i < 3000; i++) begin
      e  = ($urandom_range(99, 0) < 93);
      ld = ($urandom_range(99, 0) < 6);
      d  = ($urandom_range(9, 0) == 0) ? $urandom_range(255, 0) : $urandom_range(14, 0);
      f  = $urandom_range(15, 0);
      cyc(e, ld, d, f);
    end
    checks++;
    if (trace_bad != 0) begin
      failures++;
      $display("FAIL random_trace: %0d cycles differ, first at cycle %0d got=%h required=%h", trace_bad, bad_cyc, bad_obs, bad_exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc_n = 0; trace_bad = 0; max_q = '0; pend_seen = 1'b0;
    reset_n = 1'b0; en = 1'b0; cfg_load = 1'b0; cfg_div = '0; cfg_frac = '0;
    model_reset();
    test_reset();
    test_defaults();
    test_async_reset();
    test_fraction();
    test_mid_load();
    test_load_at_tick();
    test_illegal();
    test_boundary();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
    $fatal(1);
  end

endmodule
